// File: rtl/sample_accumulator.sv
// Sums a frame of 2^shift_sel samples and holds the sum for the downstream Shift_Divider.
// Define SAMPLE_ACC_SAT_EN to saturate the 8-bit dividend at 255 instead of wrapping it.
module sample_accumulator #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic [2:0]        shift_sel,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        dividend,
    output logic [2:0]        divisor,
    output logic              overflow
);

    localparam int ACC_W = DATA_W + 7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         shift_q, shift_d;
    logic [7:0]         dividend_q, dividend_d;
    logic [2:0]         divisor_q, divisor_d;
    logic               overflow_q, overflow_d;
    logic               accept;
    logic               load_out;
    logic [CNT_W-1:0]   frame_len;

    assign in_ready  = !rst && (state_q != HOLD);
    assign out_valid = (state_q == HOLD);
    assign accept    = in_valid && in_ready;
    assign frame_len = CNT_W'(1) << shift_q;

    assign dividend = dividend_q;
    assign divisor  = divisor_q;
    assign overflow = overflow_q;

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        load_out   = 1'b0;
        dividend_d = dividend_q;
        divisor_d  = divisor_q;
        overflow_d = overflow_q;

        // flush has priority over both a same-cycle sample and a same-cycle output handshake
        case (state_q)
            IDLE: begin
                if (flush) begin
                    acc_d = '0;
                    cnt_d = '0;
                end else if (accept) begin
                    acc_d   = ACC_W'(in_data);
                    cnt_d   = CNT_W'(1);
                    shift_d = shift_sel;
                    if (shift_sel == 3'd0) begin
                        state_d  = HOLD;
                        load_out = 1'b1;
                    end else begin
                        state_d = ACCUM;
                    end
                end
            end
            ACCUM: begin
                if (flush) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (accept) begin
                    acc_d = acc_q + ACC_W'(in_data);
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_d == frame_len) begin
                        state_d  = HOLD;
                        load_out = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (flush) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (load_out) begin
            divisor_d  = shift_d;
            overflow_d = (acc_d > ACC_W'(255));
`ifdef SAMPLE_ACC_SAT_EN
            dividend_d = (acc_d > ACC_W'(255)) ? 8'hFF : acc_d[7:0];
`else
            dividend_d = acc_d[7:0];
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            cnt_q      <= '0;
            shift_q    <= '0;
            dividend_q <= '0;
            divisor_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            dividend_q <= dividend_d;
            divisor_q  <= divisor_d;
            overflow_q <= overflow_d;
        end
    end

endmodule

// File: tb/tb_sample_accumulator.sv
// Self-checking bench for sample_accumulator: a queue of expected frame results is filled
// as frames are driven and drained as the block presents its held output.
module tb_sample_accumulator;

    logic       clk;
    logic       rst;
    logic       flush;
    logic [2:0] shift_sel;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] dividend;
    logic [2:0] divisor;
    logic       overflow;

    int compared   = 0;
    int mismatched = 0;

    typedef struct packed {
        logic [7:0] div;
        logic [2:0] dsr;
        logic       ovf;
    } exp_t;

    exp_t sb[$];

    sample_accumulator #(.DATA_W(8), .CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .shift_sel (shift_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: expected held output for a frame sum and shift selection.
    function automatic exp_t model(input int sum, input int sel);
        exp_t e;
        e.ovf = (sum > 255);
`ifdef SAMPLE_ACC_SAT_EN
        e.div = (sum > 255) ? 8'd255 : 8'(sum);
`else
        e.div = 8'(sum % 256);
`endif
        e.dsr = 3'(sel);
        return e;
    endfunction

    task automatic drive_sample(input logic [7:0] d, input logic [2:0] sel);
        in_valid  = 1'b1;
        in_data   = d;
        shift_sel = sel;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0;
        shift_sel = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        compared++;
        if ({in_ready, out_valid, dividend, divisor, overflow} !== 14'd0) begin
            mismatched++;
            $display("[TB] FAIL reset_outputs: got rdy=%b vld=%b div=%0d dsr=%0d ovf=%b, want all 0",
                     in_ready, out_valid, dividend, divisor, overflow);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        compared++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_release: got rdy=%b vld=%b, want rdy=1 vld=0", in_ready, out_valid);
        end
    endtask

    task automatic test_basic_frame();
        exp_t e;
        int   sum = 0;
        logic [7:0] samples [4] = '{8'd10, 8'd20, 8'd30, 8'd40};
        out_ready = 1'b1;
        // shift_sel changes after the first sample must not alter the frame length
        for (int i = 0; i < 4; i++) begin
            sum += samples[i];
            if (i == 3) sb.push_back(model(sum, 2));
            drive_sample(samples[i], (i == 0) ? 3'd2 : 3'd0);
        end
        compared++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL basic_latency: got vld=%b rdy=%b, want vld=1 rdy=0", out_valid, in_ready);
        end
        e = sb.pop_front();
        compared++;
        if ({dividend, divisor, overflow} !== e) begin
            mismatched++;
            $display("[TB] FAIL basic_result: got div=%0d dsr=%0d ovf=%b, want div=%0d dsr=%0d ovf=%b",
                     dividend, divisor, overflow, e.div, e.dsr, e.ovf);
        end
        @(posedge clk);
        #1;
        compared++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL basic_consume: got vld=%b rdy=%b, want vld=0 rdy=1", out_valid, in_ready);
        end
    endtask

    task automatic test_single_sample();
        exp_t e;
        out_ready = 1'b1;
        sb.push_back(model(170, 0));
        drive_sample(8'hAA, 3'd0);
        e = sb.pop_front();
        compared++;
        if ({out_valid, dividend, divisor, overflow} !== {1'b1, e}) begin
            mismatched++;
            $display("[TB] FAIL single_result: got vld=%b div=%0d dsr=%0d ovf=%b, want vld=1 div=%0d dsr=%0d ovf=%b",
                     out_valid, dividend, divisor, overflow, e.div, e.dsr, e.ovf);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_overflow();
        exp_t e;
        int   sum = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            sum += 200;
            if (i == 7) sb.push_back(model(sum, 3));
            drive_sample(8'd200, 3'd3);
        end
        e = sb.pop_front();
        compared++;
        if ({out_valid, dividend, divisor, overflow} !== {1'b1, e}) begin
            mismatched++;
            $display("[TB] FAIL overflow_result: got vld=%b div=%0d dsr=%0d ovf=%b, want vld=1 div=%0d dsr=%0d ovf=%b",
                     out_valid, dividend, divisor, overflow, e.div, e.dsr, e.ovf);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_backpressure();
        exp_t e;
        out_ready = 1'b0;
        drive_sample(8'd7, 3'd1);
        sb.push_back(model(16, 1));
        drive_sample(8'd9, 3'd1);
        e = sb.pop_front();
        // a sample offered during HOLD must be refused
        in_valid = 1'b1;
        in_data  = 8'd99;
        for (int c = 0; c < 5; c++) begin
            compared++;
            if ({out_valid, in_ready, dividend, divisor, overflow} !== {2'b10, e}) begin
                mismatched++;
                $display("[TB] FAIL hold_stable cyc%0d: got vld=%b rdy=%b div=%0d dsr=%0d ovf=%b, want vld=1 rdy=0 div=%0d dsr=%0d ovf=%b",
                         c, out_valid, in_ready, dividend, divisor, overflow, e.div, e.dsr, e.ovf);
            end
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        compared++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL hold_release: got vld=%b rdy=%b, want vld=0 rdy=1", out_valid, in_ready);
        end
    endtask

    task automatic test_flush();
        exp_t e;
        out_ready = 1'b1;
        drive_sample(8'd5, 3'd2);
        drive_sample(8'd6, 3'd2);
        flush = 1'b1;
        drive_sample(8'd7, 3'd2);
        flush = 1'b0;
        for (int c = 0; c < 3; c++) begin
            compared++;
            if (out_valid !== 1'b0) begin
                mismatched++;
                $display("[TB] FAIL flush_no_output cyc%0d: got vld=%b, want 0", c, out_valid);
            end
            @(posedge clk);
            #1;
        end
        drive_sample(8'd3, 3'd1);
        sb.push_back(model(7, 1));
        drive_sample(8'd4, 3'd1);
        e = sb.pop_front();
        compared++;
        if ({out_valid, dividend, divisor, overflow} !== {1'b1, e}) begin
            mismatched++;
            $display("[TB] FAIL flush_next_frame: got vld=%b div=%0d dsr=%0d ovf=%b, want vld=1 div=%0d dsr=%0d ovf=%b",
                     out_valid, dividend, divisor, overflow, e.div, e.dsr, e.ovf);
        end
        @(posedge clk);
        #1;
        // flush during HOLD beats a simultaneous output handshake and drops the result
        out_ready = 1'b0;
        sb.push_back(model(33, 0));
        drive_sample(8'd33, 3'd0);
        flush     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        void'(sb.pop_front());
        compared++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL flush_in_hold: got vld=%b rdy=%b, want vld=0 rdy=1", out_valid, in_ready);
        end
    endtask

    task automatic test_async_reset();
        exp_t e;
        out_ready = 1'b1;
        drive_sample(8'd50, 3'd2);
        drive_sample(8'd60, 3'd2);
        #2;
        rst = 1'b1;
        #1;
        compared++;
        if ({in_ready, out_valid, dividend, divisor, overflow} !== 14'd0) begin
            mismatched++;
            $display("[TB] FAIL reset_mid_accum: got rdy=%b vld=%b div=%0d dsr=%0d ovf=%b, want all 0",
                     in_ready, out_valid, dividend, divisor, overflow);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive_sample(8'd1, 3'd1);
        sb.push_back(model(3, 1));
        drive_sample(8'd2, 3'd1);
        e = sb.pop_front();
        compared++;
        if ({out_valid, dividend, divisor, overflow} !== {1'b1, e}) begin
            mismatched++;
            $display("[TB] FAIL post_reset_frame: got vld=%b div=%0d dsr=%0d ovf=%b, want vld=1 div=%0d dsr=%0d ovf=%b",
                     out_valid, dividend, divisor, overflow, e.div, e.dsr, e.ovf);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        sb.push_back(model(9, 0));
        drive_sample(8'd9, 3'd0);
        e = sb.pop_front();
        compared++;
        if ({out_valid, dividend, divisor, overflow} !== {1'b1, e}) begin
            mismatched++;
            $display("[TB] FAIL pre_reset_hold: got vld=%b div=%0d dsr=%0d ovf=%b, want vld=1 div=%0d dsr=%0d ovf=%b",
                     out_valid, dividend, divisor, overflow, e.div, e.dsr, e.ovf);
        end
        #2;
        rst = 1'b1;
        #1;
        compared++;
        if ({in_ready, out_valid, dividend, divisor, overflow} !== 14'd0) begin
            mismatched++;
            $display("[TB] FAIL reset_mid_hold: got rdy=%b vld=%b div=%0d dsr=%0d ovf=%b, want all 0",
                     in_ready, out_valid, dividend, divisor, overflow);
        end
        @(posedge clk);
        #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        drive_sample(8'd4, 3'd1);
        sb.push_back(model(8, 1));
        drive_sample(8'd4, 3'd1);
        e = sb.pop_front();
        compared++;
        if ({out_valid, dividend, divisor, overflow} !== {1'b1, e}) begin
            mismatched++;
            $display("[TB] FAIL post_hold_reset_frame: got vld=%b div=%0d dsr=%0d ovf=%b, want vld=1 div=%0d dsr=%0d ovf=%b",
                     out_valid, dividend, divisor, overflow, e.div, e.dsr, e.ovf);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_single_sample();
        test_overflow();
        test_backpressure();
        test_flush();
        test_async_reset();
        compared++;
        if (sb.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
